tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler_if.sv | 15 +
 rtl/tick_scheduler.sv | 84 ++++++++
 tb/tb_tick_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: control inputs and tick/level/count outputs of the tick scheduler
interface tick_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int LVL_W  = 3
);
    logic              enable;
    logic [LVL_W-1:0]  difficulty;
    logic              auto_up;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] tick;
    logic [LVL_W-1:0]  level;
    logic [15:0]       tick_count;
    modport master (output enable, difficulty, auto_up, ch_en, input tick, level, tick_count);
    modport slave  (input enable, difficulty, auto_up, ch_en, output tick, level, tick_count);
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: level-dependent periodic tick generator with round-robin channel selection
module tick_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int LVL_W      = 3,
    parameter int CNT_W      = 32,
    parameter int BASE_TICKS = 350_000_000,
    parameter int STEP_TICKS = 25_000_000,
    parameter int MIN_TICKS  = 150_000_000,
    parameter int ESC_TICKS  = 8
) (
    input logic clk,
    input logic rst,
    tick_scheduler_if.slave bus
);
    localparam int W     = CNT_W + LVL_W;
    localparam int RR_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int ESC_W = ESC_TICKS > 1 ? $clog2(ESC_TICKS) : 1;
    localparam logic [LVL_W-1:0] LMAX   = '1;
    localparam logic [W-1:0]     BASE_W = W'(BASE_TICKS);
    localparam logic [W-1:0]     STEP_W = W'(STEP_TICKS);
    localparam logic [W-1:0]     MIN_W  = W'(MIN_TICKS);
    localparam logic [W-1:0]     SLACK  = W'(BASE_TICKS - MIN_TICKS);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [RR_W-1:0]   rr_q, rr_d, sel;
    logic [ESC_W-1:0]  esc_q, esc_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [15:0]       tc_q, tc_d;
    logic [W-1:0]      dec, per;
    logic              wrap, found, fire, esc_hit;
    int                j;

    always_comb begin
        dec     = W'(level_q) * STEP_W;
        per     = dec > SLACK ? MIN_W : BASE_W - dec;
        wrap    = bus.enable && W'(cnt_q) == per - 1'b1;
        found   = 1'b0;
        sel     = '0;
        j       = 0;
        // walk downward so the channel nearest rr is the last one written
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            j = j >= NUM_CH ? j - NUM_CH : j;
            if (bus.ch_en[j]) begin
                found = 1'b1;
                sel   = RR_W'(j);
            end
        end
        fire    = wrap && found;
        esc_hit = esc_q == ESC_W'(ESC_TICKS - 1);
        cnt_d   = (!bus.enable || wrap) ? '0 : cnt_q + 1'b1;
        tick_d  = fire ? NUM_CH'(1) << sel : '0;
        rr_d    = !bus.enable ? '0 : !fire ? rr_q : sel == RR_W'(NUM_CH - 1) ? '0 : sel + 1'b1;
        tc_d    = !bus.enable ? '0 : (fire && tc_q != 16'hFFFF) ? tc_q + 1'b1 : tc_q;
        esc_d   = !bus.enable ? '0 : !(wrap && bus.auto_up) ? esc_q : esc_hit ? '0 : esc_q + 1'b1;
        level_d = !bus.enable ? bus.difficulty :
                  !wrap ? level_q :
                  !bus.auto_up ? bus.difficulty :
                  (esc_hit && level_q != LMAX) ? level_q + 1'b1 : level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            tick_q  <= '0;
            rr_q    <= '0;
            esc_q   <= '0;
            level_q <= '0;
            tc_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            rr_q    <= rr_d;
            esc_q   <= esc_d;
            level_q <= level_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.tick       = tick_q;
    assign bus.level      = level_q;
    assign bus.tick_count = tc_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench; expected ticks queued with stimulus, popped as ticks appear
module tb_tick_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ecnt;

    typedef struct {int at; logic [2:0] vec;} exp_t;
    exp_t q[$];

    tick_scheduler_if #(.NUM_CH(3), .LVL_W(3)) bus ();

    tick_scheduler #(
        .NUM_CH(3), .LVL_W(3), .CNT_W(32), .BASE_TICKS(10),
        .STEP_TICKS(2), .MIN_TICKS(4), .ESC_TICKS(2)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) ecnt <= (rst || !bus.enable) ? 0 : ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int at, input int ch);
        exp_t e;
        e.at  = at;
        e.vec = 3'(1 << ch);
        q.push_back(e);
    endtask

    task automatic start(input logic [2:0] d, input logic au, input logic [2:0] ce);
        bus.enable     = 1'b0;
        bus.difficulty = d;
        bus.auto_up    = au;
        bus.ch_en      = ce;
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tick !== 3'b000) begin
            if (q.size() == 0) chk("unexpected_tick", 32'(bus.tick), 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_edge", 32'(ecnt), 32'(e.at));
                chk("tick_vec", 32'(bus.tick), 32'(e.vec));
            end
        end
    end

    initial begin
        int t, lvl, esc, ch, p;
        bus.enable = 1'b0; bus.difficulty = 3'd5; bus.auto_up = 1'b0; bus.ch_en = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_count", 32'(bus.tick_count), 0);
        rst = 1'b0;

        start(3'd0, 1'b0, 3'b111);
        push(10, 0); push(20, 1); push(30, 2); push(40, 0);
        repeat (41) @(negedge clk);
        chk("s1_count", 32'(bus.tick_count), 4);
        chk("s1_level", 32'(bus.level), 0);
        chk("s1_sb", 32'(q.size()), 0);

        start(3'd7, 1'b0, 3'b101);
        push(4, 0); push(8, 2); push(12, 0); push(16, 2);
        repeat (17) @(negedge clk);
        chk("s2_count", 32'(bus.tick_count), 4);
        chk("s2_level", 32'(bus.level), 7);
        chk("s2_sb", 32'(q.size()), 0);

        start(3'd0, 1'b0, 3'b111);
        push(10, 0); push(16, 1); push(22, 2);
        repeat (5) @(negedge clk);
        bus.difficulty = 3'd2;
        repeat (4) @(negedge clk);
        chk("s3_level_pre", 32'(bus.level), 0);
        @(negedge clk);
        chk("s3_level_post", 32'(bus.level), 2);
        repeat (13) @(negedge clk);
        chk("s3_count", 32'(bus.tick_count), 3);
        chk("s3_sb", 32'(q.size()), 0);

        start(3'd0, 1'b1, 3'b111);
        bus.difficulty = 3'd5;
        t = 0; lvl = 0; esc = 0; ch = 0;
        for (int w = 1; w <= 18; w++) begin
            p = 10 - 2 * lvl;
            if (p < 4) p = 4;
            t += p;
            push(t, ch);
            ch = (ch + 1) % 3;
            esc++;
            if (esc == 2) begin
                esc = 0;
                if (lvl < 7) lvl++;
            end
        end
        repeat (t + 1) @(negedge clk);
        chk("s4_level", 32'(bus.level), 7);
        chk("s4_count", 32'(bus.tick_count), 18);
        chk("s4_sb", 32'(q.size()), 0);

        start(3'd0, 1'b0, 3'b000);
        repeat (30) @(negedge clk);
        chk("s5_count_idle", 32'(bus.tick_count), 0);
        bus.ch_en = 3'b010;
        push(40, 1);
        repeat (11) @(negedge clk);
        chk("s5_count", 32'(bus.tick_count), 1);
        chk("s5_sb", 32'(q.size()), 0);

        start(3'd0, 1'b0, 3'b111);
        push(10, 0);
        repeat (17) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("s6_dis_count", 32'(bus.tick_count), 0);
        chk("s6_dis_tick", 32'(bus.tick), 0);
        bus.enable = 1'b1;
        push(10, 0);
        repeat (11) @(negedge clk);
        chk("s6_reen_count", 32'(bus.tick_count), 1);
        repeat (6) @(negedge clk);
        bus.difficulty = 3'd3;
        #1 rst = 1'b1;
        #1;
        chk("s6_rst_count", 32'(bus.tick_count), 0);
        chk("s6_rst_tick", 32'(bus.tick), 0);
        chk("s6_rst_level", 32'(bus.level), 0);
        @(negedge clk);
        rst = 1'b0;
        push(10, 0); push(14, 1);
        repeat (15) @(negedge clk);
        chk("s6_post_count", 32'(bus.tick_count), 2);
        chk("s6_post_level", 32'(bus.level), 3);
        chk("sb_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
